echo_delay: RTL and testbench

ECHO_DELAY -- requirements
Module: echo_delay

---
 rtl/echo_pkg.sv | 29 ++
 rtl/echo_buf.sv | 33 +++
 rtl/echo_delay.sv | 156 +++++++++++++++
 tb/tb_echo_delay.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo/delay audio effect.
//   echo_state_t  - processing mode of echo_delay (BYPASS / FILL / RUN)
//   DEFAULT_DEPTH - default circular-buffer depth in samples
//   DEFAULT_PTR_W - default pointer width, log2(DEFAULT_DEPTH)
//   saturate16()  - clamps a 17-bit signed sum to the 16-bit signed range
package echo_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        FILL   = 2'd1,
        RUN    = 2'd2
    } echo_state_t;

    localparam int DEFAULT_DEPTH = 1024;
    localparam int DEFAULT_PTR_W = 10;

    // Overflow is visible as the two top bits of the 17-bit sum disagreeing;
    // the sign bit then says which rail to clamp to.
    function automatic logic signed [15:0] saturate16(input logic signed [16:0] x);
        logic signed [15:0] r;
        if (x[16] != x[15]) begin
            r = x[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            r = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_buf.sv
// echo_buf: DEPTH x 16 simple dual-port sample store for echo_delay.
//   clk     - write clock (rising edge)
//   wr_en   - write strobe
//   wr_addr - write index
//   wr_data - signed sample to store
//   rd_addr - read index
//   rd_data - signed sample at rd_addr (asynchronous read)
// Contents are never initialised or cleared.
module echo_buf
    import echo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = DEFAULT_PTR_W
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [PTR_W-1:0]        wr_addr,
    input  logic signed [15:0]      wr_data,
    input  logic [PTR_W-1:0]        rd_addr,
    output logic signed [15:0]      rd_data
);

    logic signed [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/echo_delay.sv
// echo_delay: streaming echo effect over a circular sample buffer.
//   clk, rst_n           - single clock, synchronous active-low reset
//   en                   - effect enable (0 = dry bypass)
//   cfg_load             - pulse: latch delay_len / decay_sel
//   delay_len            - echo delay in samples (0..DEPTH-1)
//   decay_sel            - wet attenuation, arithmetic shift by decay_sel+1
//   in_valid/in_ready    - upstream handshake, address_in/audio_in payload
//   out_valid/out_ready  - downstream handshake, address_out/audio_out payload
// Optional macro ECHO_FEEDBACK_EN: in RUN the buffer stores the mixed result,
// giving recirculating decaying echoes; otherwise it stores the dry input.
module echo_delay
    import echo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = DEFAULT_PTR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    cfg_load,
    input  logic [PTR_W-1:0]        delay_len,
    input  logic [1:0]              decay_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             address_in,
    input  logic signed [15:0]      audio_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             address_out,
    output logic signed [15:0]      audio_out
);

    echo_state_t        state_q, state_d;
    echo_state_t        mode;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   fill_q, fill_d, fill_inc;
    logic [PTR_W-1:0]   dly_q;
    logic [1:0]         decay_q;
    logic [PTR_W-1:0]   rd_idx;
    logic signed [15:0] rd_data;
    logic signed [15:0] wet;
    logic signed [16:0] sum;
    logic signed [15:0] result;
    logic signed [15:0] buf_wd;
    logic               buf_we;
    logic               accept;
    logic [2:0]         shift;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign rd_idx   = wr_ptr_q - dly_q;
    assign fill_inc = fill_q + PTR_W'(1);
    assign shift    = {1'b0, decay_q} + 3'd1;

    echo_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr_q),
        .wr_data (buf_wd),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BYPASS;
        end else begin
            state_q <= state_d;
        end
    end

    // mode is the state that governs the sample seen this cycle: en acts
    // immediately, and a zero delay skips FILL entirely.
    always_comb begin
        mode     = state_q;
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        wet      = '0;
        sum      = '0;
        result   = audio_in;
        buf_we   = 1'b0;
        buf_wd   = audio_in;

        if (!en) begin
            mode = BYPASS;
        end else if (state_q != RUN) begin
            mode = (dly_q == '0) ? RUN : FILL;
        end

        if (mode == RUN) begin
            if (dly_q != '0) begin
                wet = rd_data >>> shift;
            end
            sum    = {audio_in[15], audio_in} + {wet[15], wet};
            result = saturate16(sum);
        end

        buf_we = accept && (mode != BYPASS);
`ifdef ECHO_FEEDBACK_EN
        buf_wd = (mode == RUN) ? result : audio_in;
`else
        buf_wd = audio_in;
`endif

        state_d = mode;
        if (mode == BYPASS) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (mode == FILL) begin
                fill_d = fill_inc;
                if (fill_inc == dly_q) begin
                    state_d = RUN;
                end
            end
        end

        // The coincident sample (if any) already used the old settings above.
        if (cfg_load && en) begin
            state_d = FILL;
            fill_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            dly_q       <= '0;
            decay_q     <= '0;
            out_valid   <= 1'b0;
            address_out <= '0;
            audio_out   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            if (cfg_load) begin
                dly_q   <= delay_len;
                decay_q <= decay_sel;
            end
            if (accept) begin
                out_valid   <= 1'b1;
                address_out <= address_in;
                audio_out   <= result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: scoreboard bench for echo_delay (DEPTH=16 build).
// Stimulus pushes expected responses; a negedge monitor pops and compares
// whenever an output transfer is presented.
module tb_echo_delay;
    import echo_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    typedef struct {
        logic [31:0]        addr;
        logic signed [15:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               cfg_load = 1'b0;
    logic [PTR_W-1:0]   delay_len = '0;
    logic [1:0]         decay_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        address_in = '0;
    logic signed [15:0] audio_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [31:0]        address_out;
    logic signed [15:0] audio_out;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    echo_delay #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .cfg_load    (cfg_load),
        .delay_len   (delay_len),
        .decay_sel   (decay_sel),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .address_in  (address_in),
        .audio_in    (audio_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .address_out (address_out),
        .audio_out   (audio_out)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got addr=%0d data=%0d, required no output",
                         address_out, audio_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", int'(audio_out), int'(e.data));
                check("out_addr", int'(address_out), int'(e.addr));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic signed [15:0] d,
                        input logic signed [15:0] e);
        logic rdy;
        int unsigned waited;
        waited     = 0;
        in_valid   = 1'b1;
        address_in = a;
        audio_in   = d;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!rdy && waited < 50);
        in_valid = 1'b0;
        if (rdy) begin
            sb.push_back('{addr: a, data: e});
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1 (addr=%0d)", a);
        end
    endtask

    task automatic cfg(input logic [PTR_W-1:0] dl, input logic [1:0] ds);
        delay_len = dl;
        decay_sel = ds;
        cfg_load  = 1'b1;
        @(posedge clk);
        #1;
        cfg_load  = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] imp_exp [12];
        int x [40];
        int y [40];
        int unsigned waited;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_audio_out", int'(audio_out), 0);
        check("rst_address_out", int'(address_out), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_state", int'(dut.state_q), int'(BYPASS));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Bypass
        en = 1'b0;
        send(32'd1, 16'sd100, 16'sd100);
        send(32'd2, -16'sd200, -16'sd200);

        // Impulse, delay 4, decay shift 1
        for (int i = 0; i < 12; i++) imp_exp[i] = 16'sd0;
        imp_exp[0] = 16'sd16000;
        imp_exp[4] = 16'sd8000;
`ifdef ECHO_FEEDBACK_EN
        imp_exp[8] = 16'sd4000;
`endif
        en = 1'b1;
        cfg(4'd4, 2'd0);
        send(32'd100, 16'sd16000, imp_exp[0]);
        for (int i = 1; i < 12; i++) send(32'd100 + 32'(i), 16'sd0, imp_exp[i]);
        en = 1'b0;
        idle(1);

        // Saturation, delay 2
        en = 1'b1;
        cfg(4'd2, 2'd0);
        for (int i = 0; i < 6; i++)
            send(32'd200 + 32'(i), 16'sd30000, (i < 2) ? 16'sd30000 : 16'sd32767);
        en = 1'b0;
        idle(1);
        en = 1'b1;
        cfg(4'd2, 2'd0);
        for (int i = 0; i < 6; i++)
            send(32'd300 + 32'(i), -16'sd30000, (i < 2) ? -16'sd30000 : -16'sh8000);

        // Backpressure: output must hold while out_ready is low
        en = 1'b0;
        idle(2);
        out_ready = 1'b0;
        send(32'd10, 16'sd500, 16'sd500);
        fork
            send(32'd11, 16'sd600, 16'sd600);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", int'(in_ready), 0);
                    check("stall_out_valid", int'(out_valid), 1);
                    check("stall_audio_hold", int'(audio_out), 500);
                    check("stall_addr_hold", int'(address_out), 10);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        // Ramp across pointer wrap, delay 15
        for (int n = 0; n < 40; n++) begin
            x[n] = 100 * (n + 1);
            if (n < 15) y[n] = x[n];
`ifdef ECHO_FEEDBACK_EN
            else y[n] = x[n] + (y[n-15] >>> 1);
`else
            else y[n] = x[n] + (x[n-15] >>> 1);
`endif
        end
        en = 1'b0;
        idle(1);
        en = 1'b1;
        cfg(4'd15, 2'd0);
        for (int n = 0; n < 40; n++)
            send(32'd1000 + 32'(n), 16'(x[n]), 16'(y[n]));

        // Reconfigure mid-stream: delay 4 -> 2 re-enters FILL
        en = 1'b0;
        idle(1);
        en = 1'b1;
        cfg(4'd4, 2'd0);
        for (int i = 0; i < 6; i++)
            send(32'd2000 + 32'(i), 16'sd4000, (i < 4) ? 16'sd4000 : 16'sd6000);
        cfg(4'd2, 2'd0);
        send(32'd2010, 16'sd1000, 16'sd1000);
        send(32'd2011, 16'sd2000, 16'sd2000);
        send(32'd2012, 16'sd3000, 16'sd3500);
        send(32'd2013, 16'sd0, 16'sd1000);

        // Reset pulse with a held output sample: that sample is discarded
        idle(2);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        address_in = 32'd3000;
        audio_in   = 16'sd777;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("prst_out_valid", int'(out_valid), 0);
        check("prst_in_ready", int'(in_ready), 1);
        check("prst_state", int'(dut.state_q), int'(BYPASS));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        // Latched delay is back to 0, so the effect passes the dry sample
        send(32'd77, 16'sd1234, 16'sd1234);

        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        idle(3);
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
